// File: rtl/conv_window_gen_3x3.sv
// Streaming 3x3 window generator: raster-order 8-bit pixels in, one packed
// 72-bit window out per fully-populated position (no padding).
module conv_window_gen_3x3 #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_data,
  input  logic        pix_sof,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] win_data,
  output logic        win_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] row;
  logic [RW-1:0] cur_row;
  logic          accept;
  logic          emit;
  logic          at_col_last;
  logic          at_row_last;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];
  logic [23:0]   taps;
  logic [71:0]   win_arr;
  logic [71:0]   win_next;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The input side only stalls when an unconsumed window would be overwritten.
  assign pix_ready = !rst && (!win_valid || win_ready);
  assign accept    = pix_valid && pix_ready;

  // pix_sof relocates the current pixel to (0,0), abandoning a partial frame.
  assign cur_col     = pix_sof ? '0 : col;
  assign cur_row     = pix_sof ? '0 : row;
  assign at_col_last = (cur_col == COL_LAST);
  assign at_row_last = (cur_row == ROW_LAST);
  assign emit        = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  // Column taps, top (row r-2) in the low byte.
  assign taps = {pix_data, lb0[cur_col], lb1[cur_col]};

  always_comb begin
    win_next = '0;
    for (int wr = 0; wr < 3; wr++) begin
      win_next[24*wr +: 8]      = win_arr[24*wr + 8 +: 8];
      win_next[24*wr + 8 +: 8]  = win_arr[24*wr + 16 +: 8];
      win_next[24*wr + 16 +: 8] = taps[8*wr +: 8];
    end
  end

  // Line buffers and the shift array carry no reset; emission waits for two
  // refilled rows, so stale contents never reach win_data.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= pix_data;
      win_arr      <= win_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_data  <= '0;
    end else begin
      if (accept) begin
        if (at_col_last) begin
          col <= '0;
          row <= at_row_last ? '0 : cur_row + RW'(1);
        end else begin
          col <= cur_col + CW'(1);
          row <= cur_row;
        end
      end
      if (emit) begin
        win_data  <= win_next;
        win_valid <= 1'b1;
        win_last  <= at_row_last && at_col_last;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen_3x3.sv
// Bench for conv_window_gen_3x3: a 4x4 instance for directed frames and a
// 16x16 instance for random stalls, both checked against a frame-image model.
module tb_conv_window_gen_3x3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_pix_valid, a_pix_ready, a_pix_sof, a_win_valid, a_win_ready, a_win_last;
  logic [7:0]  a_pix_data;
  logic [71:0] a_win_data;
  logic        b_pix_valid, b_pix_ready, b_pix_sof, b_win_valid, b_win_ready, b_win_last;
  logic [7:0]  b_pix_data;
  logic [71:0] b_win_data;

  conv_window_gen_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rst(rst),
    .pix_valid(a_pix_valid), .pix_ready(a_pix_ready), .pix_data(a_pix_data), .pix_sof(a_pix_sof),
    .win_valid(a_win_valid), .win_ready(a_win_ready), .win_data(a_win_data), .win_last(a_win_last)
  );

  conv_window_gen_3x3 #(.IMG_WIDTH(16), .IMG_HEIGHT(16)) dut_b (
    .clk(clk), .rst(rst),
    .pix_valid(b_pix_valid), .pix_ready(b_pix_ready), .pix_data(b_pix_data), .pix_sof(b_pix_sof),
    .win_valid(b_win_valid), .win_ready(b_win_ready), .win_data(b_win_data), .win_last(b_win_last)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        exp_valid;
    logic [71:0] exp_data;
    logic        exp_last;
  } vec_t;
  vec_t vecs [16];

  localparam logic [71:0] W_FIRST  = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] W_SECOND = 72'h23_22_21_13_12_11_03_02_01;
  localparam logic [71:0] W_THIRD  = 72'h32_31_30_22_21_20_12_11_10;
  localparam logic [71:0] W_FOURTH = 72'h33_32_31_23_22_21_13_12_11;

  // Scoreboard state: {win_last, win_data} expected per instance.
  logic [72:0] a_q [$];
  logic [72:0] b_q [$];
  logic [71:0] a_log [$];
  int          b_frame_cnts [$];
  int          a_win_cnt = 0, a_last_cnt = 0;
  int          b_win_cnt = 0, b_last_cnt = 0, b_frame_win = 0;
  logic [7:0]  img [2][16][16];
  int          m_row [2];
  int          m_col [2];
  logic [72:0] mon_e;
  logic        mon_emit;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Model keeps the whole frame image and cuts windows out of it by coordinates.
  task automatic model_accept(input int i, input logic [7:0] d, input logic sof,
                              input int w, input int h,
                              output logic emit, output logic [72:0] exp);
    int r, c;
    r = sof ? 0 : m_row[i];
    c = sof ? 0 : m_col[i];
    img[i][r][c] = d;
    emit = (r >= 2) && (c >= 2);
    exp = '0;
    if (emit) begin
      for (int wr = 0; wr < 3; wr++)
        for (int wc = 0; wc < 3; wc++)
          exp[8*(3*wr+wc) +: 8] = img[i][r-2+wr][c-2+wc];
      exp[72] = (r == h-1) && (c == w-1);
    end
    if (c == w-1) begin
      c = 0;
      r = (r == h-1) ? 0 : r + 1;
    end else begin
      c = c + 1;
    end
    m_row[i] = r;
    m_col[i] = c;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      a_q.delete();
      b_q.delete();
      m_row = '{0, 0};
      m_col = '{0, 0};
      b_frame_win = 0;
    end else begin
      if (a_win_valid && a_win_ready) begin
        a_log.push_back(a_win_data);
        a_win_cnt++;
        if (a_win_last) a_last_cnt++;
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_window got=%h exp=none", a_win_data);
        end else begin
          mon_e = a_q.pop_front();
          check("a_win_data", a_win_data, mon_e[71:0]);
          check_int("a_win_last", int'(a_win_last), int'(mon_e[72]));
        end
      end
      if (a_pix_valid && a_pix_ready) begin
        model_accept(0, a_pix_data, a_pix_sof, 4, 4, mon_emit, mon_e);
        if (mon_emit) a_q.push_back(mon_e);
      end
      if (b_win_valid && b_win_ready) begin
        b_win_cnt++;
        b_frame_win++;
        if (b_win_last) begin
          b_last_cnt++;
          b_frame_cnts.push_back(b_frame_win);
          b_frame_win = 0;
        end
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_window got=%h exp=none", b_win_data);
        end else begin
          mon_e = b_q.pop_front();
          check("b_win_data", b_win_data, mon_e[71:0]);
          check_int("b_win_last", int'(b_win_last), int'(mon_e[72]));
        end
      end
      if (b_pix_valid && b_pix_ready) begin
        model_accept(1, b_pix_data, b_pix_sof, 16, 16, mon_emit, mon_e);
        if (mon_emit) b_q.push_back(mon_e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic sof);
    logic ok;
    ok = 1'b0;
    a_pix_valid = 1'b1;
    a_pix_data  = d;
    a_pix_sof   = sof;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (a_pix_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    a_pix_valid = 1'b0;
    a_pix_sof   = 1'b0;
    check_int("send_a_accepted", int'(ok), 1);
  endtask

  task automatic send_frame_a(input int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        send_a(8'(base + 16*r + c), 1'b0);
  endtask

  task automatic clear_a();
    a_win_cnt  = 0;
    a_last_cnt = 0;
    a_log.delete();
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [71:0] snap;
    logic        found;
    int          idx, cyc;
    logic        acc;
    logic [7:0]  cur;

    a_pix_valid = 0; a_pix_data = 0; a_pix_sof = 0; a_win_ready = 1;
    b_pix_valid = 0; b_pix_data = 0; b_pix_sof = 0; b_win_ready = 1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_pix_ready_a", int'(a_pix_ready), 0);
    check_int("rst_pix_ready_b", int'(b_pix_ready), 0);
    check_int("rst_win_valid", int'(a_win_valid), 0);
    check_int("rst_win_last", int'(a_win_last), 0);
    check("rst_win_data", a_win_data, 72'h0);
    rst = 1'b0;
    #1;
    check_int("post_rst_pix_ready", int'(a_pix_ready), 1);
    @(posedge clk);
    #1;

    // Basic frame, table-driven
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        vecs[4*r+c].data      = 8'(16*r + c);
        vecs[4*r+c].exp_valid = 1'b0;
        vecs[4*r+c].exp_data  = '0;
        vecs[4*r+c].exp_last  = 1'b0;
      end
    vecs[10].exp_valid = 1'b1; vecs[10].exp_data = W_FIRST;
    vecs[11].exp_valid = 1'b1; vecs[11].exp_data = W_SECOND;
    vecs[14].exp_valid = 1'b1; vecs[14].exp_data = W_THIRD;
    vecs[15].exp_valid = 1'b1; vecs[15].exp_data = W_FOURTH; vecs[15].exp_last = 1'b1;
    clear_a();
    for (int i = 0; i < 16; i++) begin
      send_a(vecs[i].data, 1'b0);
      check_int("basic_valid", int'(a_win_valid), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check("basic_data", a_win_data, vecs[i].exp_data);
        check_int("basic_last", int'(a_win_last), int'(vecs[i].exp_last));
      end
    end
    drain();
    check_int("basic_count", a_win_cnt, 4);
    check_int("basic_last_count", a_last_cnt, 1);

    // Backpressure: stall 5 cycles once the first window shows up
    clear_a();
    fork
      send_frame_a(0);
      begin
        found = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(posedge clk);
          #1;
          if (a_win_valid) begin
            found = 1'b1;
            break;
          end
        end
        check_int("bp_window_seen", int'(found), 1);
        a_win_ready = 1'b0;
        snap = a_win_data;
        check("bp_first_window", snap, W_FIRST);
        repeat (5) begin
          @(negedge clk);
          check_int("bp_pix_ready", int'(a_pix_ready), 0);
          check_int("bp_win_valid", int'(a_win_valid), 1);
          check("bp_win_data_stable", a_win_data, snap);
        end
        @(posedge clk);
        #1;
        a_win_ready = 1'b1;
      end
    join
    drain();
    check_int("bp_count", a_win_cnt, 4);
    check_int("bp_last_count", a_last_cnt, 1);
    check("bp_order_0", a_log[0], W_FIRST);
    check("bp_order_1", a_log[1], W_SECOND);
    check("bp_order_2", a_log[2], W_THIRD);
    check("bp_order_3", a_log[3], W_FOURTH);

    // Back-to-back frames without pix_sof
    clear_a();
    send_frame_a(0);
    send_frame_a(8'h40);
    drain();
    check_int("b2b_count", a_win_cnt, 8);
    check_int("b2b_last_count", a_last_cnt, 2);
    check("b2b_f2_first", a_log[4], 72'h62_61_60_52_51_50_42_41_40);
    check("b2b_f2_last", a_log[7], 72'h73_72_71_63_62_61_53_52_51);

    // Mid-frame resync: partial frame up to (2,0), pix_sof in place of (2,1)
    clear_a();
    for (int i = 0; i < 9; i++) begin
      send_a(8'(8'h40 + 16*(i/4) + (i%4)), 1'b0);
      check_int("resync_partial_no_win", int'(a_win_valid), 0);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        send_a(8'(8'h80 + 16*r + c), (r == 0) && (c == 0));
        check_int("resync_valid", int'(a_win_valid), int'((r >= 2) && (c >= 2)));
      end
    drain();
    check_int("resync_count", a_win_cnt, 4);
    check("resync_first", a_log[0], 72'hA2_A1_A0_92_91_90_82_81_80);
    check("resync_fourth", a_log[3], 72'hB3_B2_B1_A3_A2_A1_93_92_91);

    // Reset while a window is stalled
    clear_a();
    for (int i = 0; i < 11; i++) send_a(8'(16*(i/4) + (i%4)), 1'b0);
    a_win_ready = 1'b0;
    check_int("rstmid_pending", int'(a_win_valid), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_int("rstmid_win_valid", int'(a_win_valid), 0);
    check_int("rstmid_win_last", int'(a_win_last), 0);
    check("rstmid_win_data", a_win_data, 72'h0);
    #1;
    check_int("rstmid_pix_ready", int'(a_pix_ready), 1);
    @(posedge clk);
    #1;
    a_win_ready = 1'b1;
    clear_a();
    send_frame_a(0);
    drain();
    check_int("rstmid_count", a_win_cnt, 4);
    check_int("rstmid_last_count", a_last_cnt, 1);
    check("rstmid_first", a_log[0], W_FIRST);
    check("rstmid_fourth", a_log[3], W_FOURTH);

    // Random stalls on the 16x16 instance, 10 frames
    idx = 0;
    cyc = 0;
    cur = 8'($urandom_range(0, 255));
    while (idx < 2560 && cyc < 40000) begin
      b_pix_valid = 1'($urandom_range(0, 1));
      b_pix_data  = cur;
      b_win_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = b_pix_valid && b_pix_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        cur = 8'($urandom_range(0, 255));
      end
      cyc++;
    end
    b_pix_valid = 1'b0;
    b_win_ready = 1'b1;
    drain();
    check_int("rand_all_sent", idx, 2560);
    check_int("rand_count", b_win_cnt, 1960);
    check_int("rand_last_count", b_last_cnt, 10);
    check_int("rand_queue_empty", b_q.size(), 0);
    check_int("rand_frames", b_frame_cnts.size(), 10);
    foreach (b_frame_cnts[i]) check_int("rand_frame_windows", b_frame_cnts[i], 196);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_gen_3x3.md
# conv_window_gen_3x3

Streaming 3x3 window generator that feeds the packed 72-bit pixel window consumed by the 3x3 multi-channel convolution datapaths. It accepts a raster-order 8-bit pixel stream over a valid/ready handshake, keeps the two previous image rows in line buffers, and emits one fully-populated 3x3 window per valid output position. It uses no padding, so each frame produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows. The output is registered and carries a valid/ready handshake with backpressure.

## Interface
- IMG_WIDTH, 16: pixels per row; legal range ≥3.
- IMG_HEIGHT, 16: rows per frame; legal range ≥3.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- pix_valid  in  1  input pixel is valid.
- pix_ready  out  1  block can accept a pixel.
- pix_data  in  8  unsigned pixel value.
- pix_sof  in  1  start of frame; sampled only on an accepted pixel.
- win_valid  out  1  window on win_data is valid.
- win_ready  in  1  downstream accepts the window.
- win_data  out  72  packed window. Byte k (bits 8k+7:8k) is window pixel k, where k = 3*wr + wc, wr/wc ∈ 0..2, and index 0 is top-left. Byte 0 is image pixel (r-2, c-2) and byte 8 is image pixel (r, c).
- win_last  out  1  marks the final window of the frame.

## Operation
- Accept occurs when pix_valid && pix_ready.
- pix_ready = !rst && (!win_valid || win_ready).
- Position counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the coordinates of the next accepted pixel.
  - On each accept, col increments.
  - When col reaches IMG_WIDTH-1 it wraps to 0 and row increments.
  - When row reaches IMG_HEIGHT-1 and col reaches IMG_WIDTH-1, both wrap to 0. The next pixel starts a new frame without any pix_sof.
- pix_sof on an accepted pixel forces that pixel's position to (0,0), discarding any partial frame. Counters then continue from (0,1).
- There are two line buffers of IMG_WIDTH×8 bits each. lb0[c] holds row r-1 and lb1[c] holds row r-2.
- On accept at column c:
  - The column taps are {lb1[c], lb0[c], pix_data} for window rows 0, 1 and 2.
  - The buffers update as lb1[c] ← lb0[c] and lb0[c] ← pix_data.
- A 3x3 window register array shifts left by one column on every accept, and the new taps enter column 2.
- A window is emitted on an accept with row ≥2 and col ≥2:
  - win_data is loaded with the shifted array including the new taps.
  - win_valid is set to 1.
  - win_last = (row==IMG_HEIGHT-1 && col==IMG_WIDTH-1).
- win_valid clears when win_ready is 1 and no new window is loaded in the same cycle.
- Simultaneous win_ready and a window-producing accept: the new window replaces the old one and win_valid stays 1, giving back-to-back windows.
- Accepts with row <2 or col <2 update state only and emit no window. Window columns straddling the row wrap are never emitted.
- The line buffers and window array are not reset. Their stale contents are never visible because emission requires two fully refilled rows.
- No arithmetic is performed; pixels are transported unsigned with no width change.

## Timing
- Reset values:
  - win_valid 0, win_last 0, win_data 0.
  - row 0, col 0.
  - pix_ready 0 while rst=1.
- Reset asserted mid-frame drops any pending window. The first pixel after reset is at (0,0).
- Latency: the window appears the cycle after the accept of its bottom-right pixel.
- Throughput: one pixel per cycle with win_ready held high.
- While win_valid && !win_ready:
  - pix_ready is 0.
  - win_data and win_last are held stable.
  - No pixel is accepted, so no window is lost.
- pix_data and pix_sof are ignored on cycles without an accept.

## Test plan
- **Basic frame.** IMG_WIDTH=IMG_HEIGHT=4, pixel value = 16*row+col, win_ready=1 continuously.
  - Exactly 4 windows are produced.
  - First window: win_data = 72'h22_21_20_12_11_10_02_01_00, one cycle after pixel 0x22 is accepted, win_last=0.
  - Fourth window: 72'h33_32_31_23_22_21_13_12_11 with win_last=1.
- **Backpressure.** Same stream; hold win_ready=0 for 5 cycles after the first window.
  - pix_ready=0 and win_data stays stable during the stall.
  - After release, all 4 windows arrive in order with no loss or duplication.
- **Back-to-back frames.** Two consecutive frames with no pix_sof; frame 2 pixels = frame 1 pixels + 0x40.
  - Frame 2's first window is 72'h62_61_60_52_51_50_42_41_40.
  - No window mixes frame 1 and frame 2 rows.
- **Mid-frame resync.** Assert pix_sof on pixel (2,1) of frame 1, then send a full frame.
  - No window is emitted until row 2, col 2 of the new frame.
  - The following windows are exact.
- **Reset mid-operation.** Assert rst for 1 cycle while win_valid=1 and win_ready=0.
  - Next cycle: win_valid=0, win_last=0, win_data=0, pix_ready=1.
  - A subsequent full frame matches the basic-frame results.
- **Random stalls.** Random pix_valid and win_ready (50% each) over 10 frames with IMG_WIDTH=16, IMG_HEIGHT=16.
  - Each frame yields 196 windows.
  - All windows match a reference model.
  - win_last is asserted exactly once per frame.
